// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared widths and arbiter state encoding for the MIPS
//                write-back path.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int REG_ADR_W    = 5;
    localparam int DATA_W       = 32;
    localparam int STARVE_CNT_W = 3;

    // Which requester wins when both ask in the same cycle
    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arb_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_wb_arbiter
//  Description : Two-requester register-file write-back arbiter. Port A is
//                the main pipeline, port B the multi-cycle unit. Grants are
//                combinational; the winning write is registered onto WE/WD/Din
//                one cycle later. Writes to r0 complete the handshake but
//                never raise WE.
//                Optional starvation guard: MIPS_WB_STARVE_GUARD_EN. When
//                defined, B gains priority after STARVE_MAX consecutive
//                denied cycles; when undefined, A always wins on conflict.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_wb_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic                 Clk,
    input  logic                 Rst,

    input  logic                 A_Req,
    input  logic [REG_ADR_W-1:0] A_Adr,
    input  logic [DATA_W-1:0]    A_Data,
    output logic                 A_Gnt,

    input  logic                 B_Req,
    input  logic [REG_ADR_W-1:0] B_Adr,
    input  logic [DATA_W-1:0]    B_Data,
    output logic                 B_Gnt,

    output logic                 WE,
    output logic [REG_ADR_W-1:0] WD,
    output logic [DATA_W-1:0]    Din
);

    // Reject configurations the 3-bit starvation counter cannot represent
    generate
        if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_starve_max_range
            $error("mips_wb_arbiter: STARVE_MAX must be in 1..7");
        end
    endgenerate

    logic                 w_a_gnt;
    logic                 w_b_gnt;
    logic                 w_xfer;
    logic [REG_ADR_W-1:0] w_adr;
    logic [DATA_W-1:0]    w_data;

    logic                 r_we;
    logic [REG_ADR_W-1:0] r_wd;
    logic [DATA_W-1:0]    r_din;

`ifdef MIPS_WB_STARVE_GUARD_EN
    localparam logic [STARVE_CNT_W-1:0] c_starve_max = STARVE_CNT_W'(STARVE_MAX);

    arb_state_t              r_state;
    arb_state_t              w_state_next;
    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic [STARVE_CNT_W-1:0] w_starve_cnt_next;

    // Priority state and starvation counter registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= PRI_A;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    // Grants, starvation count and next priority state. The switch to PRI_B
    // looks at the updated count so B wins in the cycle right after its
    // STARVE_MAX-th denial rather than one cycle later.
    always_comb begin
        w_a_gnt           = 1'b0;
        w_b_gnt           = 1'b0;
        w_state_next      = r_state;
        w_starve_cnt_next = '0;

        if (!Rst) begin
            case (r_state)
                PRI_A: begin
                    w_a_gnt = A_Req;
                    w_b_gnt = B_Req && !A_Req;
                end
                PRI_B: begin
                    w_b_gnt = B_Req;
                    w_a_gnt = A_Req && !B_Req;
                end
                default: begin
                    w_a_gnt = 1'b0;
                    w_b_gnt = 1'b0;
                end
            endcase
        end

        if (B_Req && !w_b_gnt) begin
            w_starve_cnt_next = (r_starve_cnt == '1) ? r_starve_cnt
                                                     : r_starve_cnt + 3'd1;
        end

        case (r_state)
            PRI_A: if (w_starve_cnt_next >= c_starve_max) w_state_next = PRI_B;
            PRI_B: if (w_b_gnt)                           w_state_next = PRI_A;
            default:                                      w_state_next = PRI_A;
        endcase
    end
`else
    // Fixed priority: A always wins a conflict
    always_comb begin
        w_a_gnt = !Rst && A_Req;
        w_b_gnt = !Rst && B_Req && !A_Req;
    end
`endif

    assign A_Gnt  = w_a_gnt;
    assign B_Gnt  = w_b_gnt;
    assign w_xfer = w_a_gnt | w_b_gnt;
    assign w_adr  = w_b_gnt ? B_Adr  : A_Adr;
    assign w_data = w_b_gnt ? B_Data : A_Data;

    // Capture the winning write; address and data hold when nothing transfers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_we  <= 1'b0;
            r_wd  <= '0;
            r_din <= '0;
        end else begin
            r_we <= w_xfer && (w_adr != '0);
            if (w_xfer) begin
                r_wd  <= w_adr;
                r_din <= w_data;
            end
        end
    end

    // Outputs read as zero for the whole time reset is high, which also kills
    // a write that was captured on the edge just before reset rose.
    assign WE  = r_we && !Rst;
    assign WD  = Rst ? '0 : r_wd;
    assign Din = Rst ? '0 : r_din;

endmodule : mips_wb_arbiter
`default_nettype wire

// File: tb/tb_mips_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mips_wb_arbiter
//  Description : Self-checking bench for mips_wb_arbiter with a write
//                scoreboard. Follows MIPS_WB_STARVE_GUARD_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_wb_arbiter;
    import mips_pkg::*;

    localparam int c_starve_max = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] din;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [4:0]  a_adr = '0, b_adr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_gnt, b_gnt, we;
    logic [4:0]  wd;
    logic [31:0] din;

    wr_t         q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_pri_b = 1'b0;
    int          m_cnt = 0;
    logic [4:0]  m_wd = '0;
    logic [31:0] m_din = '0;
    logic        last_b_gnt = 1'b0;

    always #5 clk = ~clk;

    mips_wb_arbiter #(.STARVE_MAX(c_starve_max)) dut (
        .Clk    (clk),
        .Rst    (rst),
        .A_Req  (a_req),
        .A_Adr  (a_adr),
        .A_Data (a_data),
        .A_Gnt  (a_gnt),
        .B_Req  (b_req),
        .B_Adr  (b_adr),
        .B_Data (b_data),
        .B_Gnt  (b_gnt),
        .WE     (we),
        .WD     (wd),
        .Din    (din)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs of the previous cycle's
    // transfer and this cycle's grants, then advance the reference model.
    task automatic step(input logic r, input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                        input logic br, input logic [4:0] ba, input logic [31:0] bd);
        wr_t  e;
        logic ea, eb;
        @(posedge clk);
        #1;
        rst = r; a_req = ar; a_adr = aa; a_data = ad;
        b_req = br; b_adr = ba; b_data = bd;
        #1;
        e = (q.size() > 0) ? q.pop_front() : '0;
        if (r) e = '0;
        check_eq("we",  we,  e.we);
        check_eq("wd",  wd,  e.wd);
        check_eq("din", din, e.din);

        ea = !r && ar && !(br && m_pri_b);
        eb = !r && br && !ea;
        check_eq("a_gnt", a_gnt, ea);
        check_eq("b_gnt", b_gnt, eb);
        last_b_gnt = eb;

        if (r) begin
            m_wd = '0; m_din = '0;
            q.push_back('0);
        end else if (ea || eb) begin
            m_wd  = ea ? aa : ba;
            m_din = ea ? ad : bd;
            q.push_back({(m_wd != 5'd0), m_wd, m_din});
        end else begin
            q.push_back({1'b0, m_wd, m_din});
        end

`ifdef MIPS_WB_STARVE_GUARD_EN
        if (r) begin
            m_pri_b = 1'b0; m_cnt = 0;
        end else begin
            if (br && !eb) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
            else           m_cnt = 0;
            if (!m_pri_b && m_cnt >= c_starve_max) m_pri_b = 1'b1;
            else if (m_pri_b && eb)                m_pri_b = 1'b0;
        end
`else
        m_pri_b = 1'b0;
        m_cnt   = 0;
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] bdat;
        logic [9:0]  exp_b;

        // Reset with both requests high: no grants, zero outputs
        step(1'b1, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222);
        step(1'b1, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222);
        idle();

        // Lone A to r5
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle();
        check_eq("lone_a_we",  we,  1'b1);
        check_eq("lone_a_wd",  wd,  5'd5);
        check_eq("lone_a_din", din, 32'hDEADBEEF);
        idle();
        check_eq("lone_a_we_drop", we, 1'b0);

        // B to r0: handshake completes, no write enable
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        idle();
        check_eq("zero_reg_we", we, 1'b0);
        idle();

        // Sustained conflict; B holds its request data until granted
`ifdef MIPS_WB_STARVE_GUARD_EN
        exp_b = 10'b10_0001_0000;   // B wins in cycles 5 and 10
`else
        exp_b = 10'b00_0000_0000;
`endif
        bdat = 32'hB000_0000;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 5'd1, 32'hA000_0000 + 32'(i), 1'b1, 5'd2, bdat);
            check_eq("starve_b_gnt", b_gnt, exp_b[i]);
            if (last_b_gnt) bdat = bdat + 32'd1;
        end
        // A drops: B must win immediately
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, bdat);
        check_eq("a_drop_b_gnt", b_gnt, 1'b1);
        idle();

        // Build up starvation, grant A, then reset on the following cycle
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'd9, 32'hC000_0000 + 32'(i), 1'b1, 5'd10, 32'hD000_0000);
        step(1'b1, 1'b1, 5'd9, 32'hC000_0004, 1'b1, 5'd10, 32'hD000_0000);
        check_eq("rst_mid_we", we, 1'b0);
        // After reset the priority is back to A
        step(1'b0, 1'b1, 5'd9, 32'hC000_0005, 1'b1, 5'd10, 32'hD000_0000);
        check_eq("post_rst_a_gnt", a_gnt, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hD000_0000);
        idle();

        // Back-to-back writes to r7: A then B
        step(1'b0, 1'b1, 5'd7, 32'hAAAA_0007, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBBBB_0007);
        check_eq("b2b_we_1",  we,  1'b1);
        check_eq("b2b_din_1", din, 32'hAAAA_0007);
        idle();
        check_eq("b2b_we_2",  we,  1'b1);
        check_eq("b2b_wd_2",  wd,  5'd7);
        check_eq("b2b_din_2", din, 32'hBBBB_0007);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mips_wb_arbiter
`default_nettype wire

// File: doc/mips_wb_arbiter.md
MIPS_WB_ARBITER -- requirements
Module: mips_wb_arbiter

Interface
REQ-001 The block SHALL have one parameter, STARVE_MAX: default 4 (range 1-7); the number of consecutive denied B-request cycles before B gains priority.
REQ-002 Clk  input  1  is the sole clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-004 A_Req  input  1  is the write-back request from the main pipeline.
REQ-005 A_Adr  input  5  is the A destination register.
REQ-006 A_Data  input  32  is the A write data.
REQ-007 A_Gnt  output  1  is the A grant, combinational from state and requests.
REQ-008 B_Req  input  1  is the write-back request from the multi-cycle unit (mul/div, load).
REQ-009 B_Adr  input  5  is the B destination register.
REQ-010 B_Data  input  32  is the B write data.
REQ-011 B_Gnt  output  1  is the B grant, combinational.
REQ-012 WE  output  1  is the registered register-file write enable.
REQ-013 WD  output  5  is the registered register-file write address.
REQ-014 Din  output  32  is the registered register-file write data.

Function
REQ-015 A transfer SHALL occur when Req and Gnt are both high in the same cycle; a requester SHALL hold Req, Adr and Data stable until granted.
REQ-016 At most one of A_Gnt and B_Gnt SHALL be high in any cycle, and a Gnt SHALL never assert without its Req.
REQ-017 The FSM SHALL have two states: PRI_A (A wins on conflict) and PRI_B (B wins on conflict); a lone requester SHALL always be granted in the same cycle.
REQ-018 The 3-bit counter starve_cnt SHALL increment when B_Req=1 and B_Gnt=0, and SHALL clear when B_Gnt=1 or B_Req=0.
REQ-019 The FSM SHALL move from PRI_A to PRI_B when starve_cnt reaches STARVE_MAX, and SHALL return to PRI_A on the cycle after any B transfer.
REQ-020 A granted transfer SHALL drive WE=1, WD=Adr and Din=Data on the next rising edge, for exactly one cycle, so they are stable at the register file's falling-edge write.
REQ-021 A granted transfer with Adr=0 SHALL complete the handshake but leave WE=0, with WD and Din updated.
REQ-022 In cycles with no transfer, WE SHALL be 0 and WD and Din SHALL hold their previous values.
REQ-023 When A and B target the same register, the later transfer SHALL be the last write; the block SHALL NOT reorder or merge writes.
REQ-024 Write latency from grant to WE SHALL be exactly 1 cycle, giving a sustained throughput of one write per cycle.

Reset
REQ-025 While Rst=1: WE=0, WD=0, Din=0, starve_cnt=0, state=PRI_A, and A_Gnt=B_Gnt=0 regardless of requests.
REQ-026 A reset asserted in the cycle after a grant SHALL suppress the pending WE; the requester SHALL re-request after reset.

Configuration
REQ-027 The macro MIPS_WB_STARVE_GUARD_EN SHALL control the starvation guard.
REQ-028 With MIPS_WB_STARVE_GUARD_EN defined, the behaviour in REQ-018 and REQ-019 SHALL apply.
REQ-029 Without MIPS_WB_STARVE_GUARD_EN, the FSM and counter SHALL be absent and A SHALL always win on conflict (fixed priority).

Structure
REQ-030 The shared package mips_pkg SHALL hold REG_ADR_W=5, DATA_W=32 and the arbiter state enum (PRI_A, PRI_B).
REQ-031 The block SHALL be flat with no sub-module; the starvation logic SHALL be a macro-guarded region inside it.

Verification
REQ-032 Lone A: A_Req=1, A_Adr=5, A_Data=0xDEADBEEF -> A_Gnt=1 the same cycle; next cycle WE=1, WD=5, Din=0xDEADBEEF; the cycle after, WE=0.
REQ-033 Zero register: B_Req=1, B_Adr=0, B_Data=0x1234 -> B_Gnt=1; next cycle WE=0.
REQ-034 Starvation (guard on, STARVE_MAX=4): A_Req and B_Req held high -> A granted for cycles 1-4, B_Gnt=1 in cycle 5, A granted again in cycle 6.
REQ-035 Guard off, same stimulus as REQ-034 -> B_Gnt stays 0 for as long as A_Req=1; B is granted in the first cycle A_Req=0.
REQ-036 Reset mid-operation: A granted in cycle N, Rst=1 in cycle N+1 -> WE=0 in N+1, both Gnt=0, starve_cnt=0, state=PRI_A.
REQ-037 Back-to-back writes: A to r7 then B to r7 on consecutive cycles -> WE high for two consecutive cycles, WD=7, Din showing A then B data.
